picorv32_mem_model: RTL and testbench
=====================================

# picorv32_mem_model

Parametrised memory and MMIO slave for the picorv32 native memory interface, used by the simulation benches. It is the successor to the ad-hoc combinational memory-plus-stall logic. It provides the following:
- a word-addressed RAM with byte strobes;
- a configurable wait-state generator: none, fixed, or LFSR pseudo-random;
- console, pass-flag and cycle-timer registers;
- a sticky error flag for unmapped accesses.

All responses are registered, and the model is synthesisable apart from the RAM init file.

## Interface
Parameters:
- MEM_WORDS, 32768: RAM depth in 32-bit words. Mapped range is 0 to MEM_WORDS*4-1.
- INIT_FILE, "firmware.hex": $readmemh image for the RAM. Empty string means no init.
- STALL_MODE, 1: wait-state mode.
  - 0: no wait states.
  - 1: fixed STALL_CYCLES wait states.
  - 2: LFSR wait states.
- STALL_CYCLES, 2: wait states in mode 1. Range 0–15.
- LFSR_SEED, 16'hACE1: LFSR reset value. Must be non-zero.
- CONSOLE_ADDR, 32'h1000_0000: console register address.
- PASS_ADDR, 32'h2000_0000: pass register address.
- TIMER_ADDR, 32'h3000_0000: cycle timer address.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  request valid. The master holds request fields stable until mem_ready.
- mem_instr  in  1  instruction fetch. Ignored except for the error flag.
- mem_addr  in  32  byte address. Bits [1:0] are ignored.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte write strobes. 0 means read.
- mem_ready  out  1  one-cycle registered response strobe.
- mem_rdata  out  32  registered read data, valid while mem_ready=1.
- console_valid  out  1  one-cycle pulse on a console write.
- console_data  out  8  console byte, valid with console_valid.
- pass  out  1  sticky: a write to PASS_ADDR has occurred.
- error  out  1  sticky: an access hit no mapped region.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- IDLE, with mem_valid=1:
  - Load the wait counter N.
  - Mode 0: N=0. Mode 1: N=STALL_CYCLES. Mode 2: N=lfsr[2:0].
  - Go to RESP if N=0, otherwise go to WAIT.
- WAIT:
  - Decrement N each cycle and go to RESP when N reaches 1.
  - If mem_valid drops in WAIT, abort to IDLE. No ready, no side effects.
- RESP:
  - mem_ready=1 for exactly this cycle, and the side effect commits at the end of it.
  - Next state is always IDLE, so every transaction has at least one ready-low cycle between responses.
- Address decode is evaluated on the RESP-entry edge, with this priority:
  1. CONSOLE_ADDR
  2. PASS_ADDR
  3. TIMER_ADDR
  4. RAM (mem_addr < MEM_WORDS*4)
  5. unmapped
- RAM:
  - Read returns the word at mem_addr>>2.
  - Write updates only the bytes whose mem_wstrb bit is set.
- Console:
  - A write with mem_wstrb[0]=1 pulses console_valid in the RESP cycle, with console_data=mem_wdata[7:0].
  - Reads return 0.
- Pass:
  - A write with any strobe set sets pass. It stays set until reset.
  - Reads return 0.
- Timer:
  - A free-running 32-bit counter increments every cycle and wraps from 0xFFFF_FFFF to 0.
  - A read returns the counter value sampled on the RESP-entry edge.
  - A write with any strobe set loads mem_wdata in full; the strobe pattern is ignored. The counter then continues incrementing from that value.
- Unmapped:
  - Complete the handshake normally. Reads return 0 and writes are dropped.
  - Set error (sticky).
- LFSR:
  - 16-bit Galois LFSR, taps 0xB400 (x^16+x^14+x^13+x^11+1).
  - Shifts every cycle regardless of traffic.
- mem_rdata is 0 in every cycle where mem_ready=0.

## Timing
- Reset values:
  - mem_ready=0, mem_rdata=0.
  - console_valid=0, console_data=0.
  - pass=0, error=0.
  - timer=0, lfsr=LFSR_SEED, FSM=IDLE.
  - RAM contents are not reset.
- Latency: mem_valid first seen high on edge t gives mem_ready high in cycle t+1+N. In mode 0, ready comes one cycle after valid.
- Throughput: at most one transaction per N+2 cycles.
- Reset during WAIT or RESP: the write does not commit, and all outputs take their reset values on the next edge.
- Decode boundaries:
  - Address MEM_WORDS*4-4 is RAM.
  - Address MEM_WORDS*4 is unmapped.
- The timer increments in the same cycle as a write-load without conflict: the loaded value wins, and the increment resumes on the next edge.

## Test plan
- Mode 0 RAM write/read:
  - Write 0xDEADBEEF to 0x100 with wstrb=4'b1111, then write 0x000000AA with wstrb=4'b0001.
  - Reading 0x100 returns 0xDEADBEAA.
  - Each ready arrives one cycle after valid.
- Mode 1 with STALL_CYCLES=3: every read has ready exactly 4 cycles after valid rises, and ready is high for exactly one cycle.
- Console and pass:
  - Writing 0x41 to CONSOLE_ADDR gives one console_valid pulse with console_data=0x41.
  - Writing to PASS_ADDR sets pass. It stays 1 through subsequent traffic and clears only on reset.
- Timer:
  - Write 0xFFFF_FFFE to TIMER_ADDR, then read it back after k cycles. The value equals 0xFFFF_FFFE plus elapsed cycles, modulo 2^32, so wrap is exercised.
- Unmapped access and abort:
  - Reading 0x4000_0000 returns ready with rdata=0 and sets error.
  - In mode 1, dropping mem_valid in WAIT gives no ready and leaves the RAM unchanged.
- Reset mid-transaction and mode 2:
  - Asserting reset during WAIT of a write leaves the target RAM word unchanged and all outputs at their reset values.
  - In mode 2, 1000 random accesses each see a latency of 1 to 8 cycles, matching a reference LFSR model seeded 0xACE1.

Source files
------------

// File: rtl/picorv32_mem_model.sv
// picorv32_mem_model: registered RAM / MMIO slave for the picorv32 native
// memory interface. Every response is a one-cycle registered mem_ready pulse
// preceded by 0..N wait states (none, fixed, or LFSR pseudo-random).
module picorv32_mem_model #(
  parameter int unsigned MEM_WORDS    = 32768,
  parameter string       INIT_FILE    = "firmware.hex",
  parameter int unsigned STALL_MODE   = 1,
  parameter int unsigned STALL_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
  parameter logic [31:0] TIMER_ADDR   = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        console_valid,
  output logic [7:0]  console_data,
  output logic        pass,
  output logic        error
);

  localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) * 33'd4;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_e;
  typedef enum logic [2:0] {
    RG_CONSOLE = 3'd0, RG_PASS = 3'd1, RG_TIMER = 3'd2, RG_RAM = 3'd3, RG_NONE = 3'd4
  } region_e;

  // Galois step, taps x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [31:0]   timer_q, timer_d;
  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          cvalid_q, cvalid_d;
  logic [7:0]    cdata_q, cdata_d;
  logic          pass_q, pass_d;
  logic          error_q, error_d;
  // Request captured on RESP entry; committed on RESP exit
  region_e       region_q, region_d;
  logic [AW-1:0] widx_q, widx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   ram_q [MEM_WORDS];

  logic [31:0]   addr_s;
  logic [AW-1:0] idx_s;
  region_e       region_s;
  logic [3:0]    stall_n_s;
  logic          enter_resp_s;
  logic          commit_s;
  logic          ram_we_s;
  logic          unused_s;

  // Word-aligned address decode with fixed priority console > pass > timer > RAM
  always_comb begin
    addr_s   = mem_addr & 32'hFFFF_FFFC;
    idx_s    = mem_addr[AW+1:2];
    unused_s = mem_instr;
    if (addr_s == CONSOLE_ADDR) begin
      region_s = RG_CONSOLE;
    end else if (addr_s == PASS_ADDR) begin
      region_s = RG_PASS;
    end else if (addr_s == TIMER_ADDR) begin
      region_s = RG_TIMER;
    end else if ({1'b0, addr_s} < RAM_BYTES) begin
      region_s = RG_RAM;
    end else begin
      region_s = RG_NONE;
    end
  end

  // Wait-state count loaded when a request is accepted in IDLE
  always_comb begin
    case (STALL_MODE)
      32'd0:   stall_n_s = 4'd0;
      32'd1:   stall_n_s = 4'(STALL_CYCLES);
      32'd2:   stall_n_s = {1'b0, lfsr_q[2:0]};
      default: stall_n_s = 4'd0;
    endcase
  end

  // Next-state logic: IDLE -> (WAIT x N) -> RESP -> IDLE, abort on dropped valid
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          cnt_d   = stall_n_s;
          state_d = (stall_n_s == 4'd0) ? ST_RESP : ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!mem_valid) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Response data on RESP entry, side effects on RESP exit, free-running timer/LFSR
  always_comb begin
    enter_resp_s = (state_d == ST_RESP);
    commit_s     = (state_q == ST_RESP);
    ready_d      = enter_resp_s;
    rdata_d      = 32'd0;
    cvalid_d     = 1'b0;
    cdata_d      = cdata_q;
    region_d     = region_q;
    widx_d       = widx_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    pass_d       = pass_q;
    error_d      = error_q;
    ram_we_s     = 1'b0;
    timer_d      = timer_q + 32'd1;
    lfsr_d       = lfsr_next(lfsr_q);

    if (enter_resp_s) begin
      region_d = region_s;
      widx_d   = idx_s;
      wdata_d  = mem_wdata;
      wstrb_d  = mem_wstrb;
      if (mem_wstrb == 4'd0) begin
        case (region_s)
          RG_TIMER: rdata_d = timer_q;
          RG_RAM:   rdata_d = ram_q[idx_s];
          default:  rdata_d = 32'd0;
        endcase
      end else if ((region_s == RG_CONSOLE) && mem_wstrb[0]) begin
        cvalid_d = 1'b1;
        cdata_d  = mem_wdata[7:0];
      end else begin
        rdata_d = 32'd0;
      end
    end else begin
      rdata_d = 32'd0;
    end

    if (commit_s) begin
      case (region_q)
        RG_PASS:  pass_d   = pass_q | (wstrb_q != 4'd0);
        RG_TIMER: timer_d  = (wstrb_q != 4'd0) ? wdata_q : timer_q + 32'd1;
        RG_RAM:   ram_we_s = (wstrb_q != 4'd0);
        RG_NONE:  error_d  = 1'b1;
        default:  error_d  = error_q;
      endcase
    end else begin
      ram_we_s = 1'b0;
    end
  end

  // State, response and peripheral registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      lfsr_q   <= LFSR_SEED;
      timer_q  <= 32'd0;
      ready_q  <= 1'b0;
      rdata_q  <= 32'd0;
      cvalid_q <= 1'b0;
      cdata_q  <= 8'd0;
      pass_q   <= 1'b0;
      error_q  <= 1'b0;
      region_q <= RG_NONE;
      widx_q   <= '0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      timer_q  <= timer_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      cvalid_q <= cvalid_d;
      cdata_q  <= cdata_d;
      pass_q   <= pass_d;
      error_q  <= error_d;
      region_q <= region_d;
      widx_q   <= widx_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
    end
  end

  // RAM byte-lane write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (ram_we_s && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) ram_q[widx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign mem_ready     = ready_q;
  assign mem_rdata     = rdata_q;
  assign console_valid = cvalid_q;
  assign console_data  = cdata_q;
  assign pass          = pass_q;
  assign error         = error_q;

endmodule

// File: tb/tb_picorv32_mem_model.sv
// Bench for picorv32_mem_model: three instances (no stall, fixed 3 stalls,
// LFSR stalls) share one request bus; each check targets one instance.
module tb_picorv32_mem_model;

  localparam int          MW     = 1024;
  localparam logic [31:0] CON_A  = 32'h1000_0000;
  localparam logic [31:0] PASS_A = 32'h2000_0000;
  localparam logic [31:0] TMR_A  = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [3:0]  mem_wstrb = 4'd0;

  logic [2:0]  rdy, cv, ps, er;
  logic [31:0] rdv [3];
  logic [7:0]  cdv [3];

  int          tests = 0;
  int          failed = 0;
  int unsigned edges = 0;
  logic        cap_cv;
  logic [7:0]  cap_cd;

  always #5 clk = ~clk;

  // Non-reset edges since the last reset edge: the age of the timer and LFSR
  always @(posedge clk) begin
    if (reset) edges = 0;
    else edges = edges + 1;
  end

  picorv32_mem_model #(.MEM_WORDS(MW), .INIT_FILE(""), .STALL_MODE(0), .STALL_CYCLES(0)) u_m0 (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(rdy[0]), .mem_rdata(rdv[0]), .console_valid(cv[0]),
    .console_data(cdv[0]), .pass(ps[0]), .error(er[0]));

  picorv32_mem_model #(.MEM_WORDS(MW), .INIT_FILE(""), .STALL_MODE(1), .STALL_CYCLES(3)) u_m1 (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(rdy[1]), .mem_rdata(rdv[1]), .console_valid(cv[1]),
    .console_data(cdv[1]), .pass(ps[1]), .error(er[1]));

  picorv32_mem_model #(.MEM_WORDS(MW), .INIT_FILE(""), .STALL_MODE(2), .LFSR_SEED(16'hACE1)) u_m2 (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(rdy[2]), .mem_rdata(rdv[2]), .console_valid(cv[2]),
    .console_data(cdv[2]), .pass(ps[2]), .error(er[2]));

  typedef struct {
    int          inst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        chk;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // LFSR state after k shifts from the seed
  function automatic logic [15:0] lfsr_at(input int unsigned k);
    logic [15:0] s = 16'hACE1;
    for (int unsigned i = 0; i < k; i++) s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    return s;
  endfunction

  // One handshake against instance inst; lat counts cycles from valid to ready
  task automatic xact(input int inst, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, output logic [31:0] rd, output int lat);
    mem_addr = a; mem_wdata = wd; mem_wstrb = ws; mem_valid = 1'b1; lat = 0;
    do begin
      step();
      lat++;
    end while (rdy[inst] !== 1'b1 && lat < 40);
    rd = rdv[inst]; cap_cv = cv[inst]; cap_cd = cdv[inst];
    if (rdy[inst] !== 1'b1) check("handshake timeout", {31'd0, rdy[inst]}, 32'd1);
    mem_valid = 1'b0; mem_wstrb = 4'd0;
    step();
    check("ready single cycle", {31'd0, rdy[inst]}, 32'd0);
    check("rdata zero when idle", rdv[inst], 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, wd, m;
    logic [3:0]  ws;
    int          lat, w, exp_lat;
    int unsigned e0, e_load;
    logic [31:0] ref_mem [64];
    logic [3:0]  ref_kn [64];

    vecs[0]  = '{0, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0, 1};
    vecs[1]  = '{0, 32'h0000_0100, 32'h0000_00AA, 4'b0001, 1'b0, 32'h0, 1};
    vecs[2]  = '{0, 32'h0000_0100, 32'h0,         4'b0000, 1'b1, 32'hDEAD_BEAA, 1};
    vecs[3]  = '{0, 32'h0000_0104, 32'h1122_3344, 4'b1111, 1'b0, 32'h0, 1};
    vecs[4]  = '{0, 32'h0000_0106, 32'hAABB_CCDD, 4'b1010, 1'b0, 32'h0, 1};
    vecs[5]  = '{0, 32'h0000_0104, 32'h0,         4'b0000, 1'b1, 32'hAA22_CC44, 1};
    vecs[6]  = '{0, 32'h0000_0FFC, 32'h1234_5678, 4'b1111, 1'b0, 32'h0, 1};
    vecs[7]  = '{0, 32'h0000_0FFC, 32'h0,         4'b0000, 1'b1, 32'h1234_5678, 1};
    vecs[8]  = '{1, 32'h0000_0200, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h0, 4};
    vecs[9]  = '{1, 32'h0000_0200, 32'h0055_0000, 4'b0100, 1'b0, 32'h0, 4};
    vecs[10] = '{1, 32'h0000_0200, 32'h0,         4'b0000, 1'b1, 32'hCA55_F00D, 4};

    // Reset state
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      check("reset ready", {31'd0, rdy[i]}, 32'd0);
      check("reset rdata", rdv[i], 32'd0);
      check("reset console", {23'd0, cv[i], cdv[i]}, 32'd0);
      check("reset pass/error", {30'd0, ps[i], er[i]}, 32'd0);
    end
    reset = 1'b0;
    step();

    // Timer counts from zero after reset
    e0 = edges;
    xact(0, TMR_A, 32'd0, 4'd0, rd, lat);
    check("timer since reset", rd, 32'(e0));

    // Table-driven RAM traffic, mode 0 and mode 1
    for (int i = 0; i < NV; i++) begin
      xact(vecs[i].inst, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (vecs[i].chk) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
    end

    // Console pulse and sticky pass
    check("pass before write", {31'd0, ps[0]}, 32'd0);
    xact(0, CON_A, 32'h0000_0041, 4'b0001, rd, lat);
    check("console pulse", {31'd0, cap_cv}, 32'd1);
    check("console data", {24'd0, cap_cd}, 32'h41);
    check("console pulse ends", {31'd0, cv[0]}, 32'd0);
    xact(0, CON_A, 32'd0, 4'd0, rd, lat);
    check("console read zero", rd, 32'd0);
    xact(0, PASS_A, 32'd1, 4'b1000, rd, lat);
    check("pass set", {31'd0, ps[0]}, 32'd1);
    xact(0, PASS_A, 32'd0, 4'd0, rd, lat);
    check("pass read zero", rd, 32'd0);
    xact(0, 32'h0000_0100, 32'd0, 4'd0, rd, lat);
    check("pass sticky", {31'd0, ps[0]}, 32'd1);

    // Timer load and wrap
    xact(0, TMR_A, 32'hFFFF_FFFE, 4'b0010, rd, lat);
    e_load = edges;
    repeat (5) step();
    e0 = edges;
    xact(0, TMR_A, 32'd0, 4'd0, rd, lat);
    check("timer wrap", rd, 32'hFFFF_FFFE + 32'(e0 - e_load));

    // Unmapped accesses
    check("error before", {31'd0, er[0]}, 32'd0);
    xact(0, 32'h4000_0000, 32'd0, 4'd0, rd, lat);
    check("unmapped rdata", rd, 32'd0);
    check("unmapped latency", 32'(lat), 32'd1);
    check("unmapped error", {31'd0, er[0]}, 32'd1);
    check("error before boundary", {31'd0, er[1]}, 32'd0);
    xact(1, 32'h0000_1000, 32'd0, 4'd0, rd, lat);
    check("boundary rdata", rd, 32'd0);
    check("boundary error", {31'd0, er[1]}, 32'd1);

    // Abort in WAIT: no ready, no write
    xact(1, 32'h0000_0300, 32'h1111_1111, 4'hF, rd, lat);
    mem_addr = 32'h0000_0300; mem_wdata = 32'h2222_2222; mem_wstrb = 4'hF; mem_valid = 1'b1;
    repeat (2) begin
      step();
      check("abort no ready", {31'd0, rdy[1]}, 32'd0);
    end
    mem_valid = 1'b0; mem_wstrb = 4'd0;
    repeat (3) begin
      step();
      check("abort stays idle", {31'd0, rdy[1]}, 32'd0);
    end
    xact(1, 32'h0000_0300, 32'd0, 4'd0, rd, lat);
    check("abort ram intact", rd, 32'h1111_1111);
    check("abort latency", 32'(lat), 32'd4);

    // Reset during WAIT of a write
    xact(1, 32'h0000_0304, 32'hAAAA_5555, 4'hF, rd, lat);
    mem_addr = 32'h0000_0304; mem_wdata = 32'h5555_AAAA; mem_wstrb = 4'hF; mem_valid = 1'b1;
    repeat (2) step();
    reset = 1'b1;
    step();
    check("midreset ready", {31'd0, rdy[1]}, 32'd0);
    check("midreset rdata", rdv[1], 32'd0);
    check("midreset console", {23'd0, cv[1], cdv[1]}, 32'd0);
    check("midreset error", {31'd0, er[1]}, 32'd0);
    check("midreset pass", {31'd0, ps[1]}, 32'd0);
    check("pass cleared by reset", {31'd0, ps[0]}, 32'd0);
    reset = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'd0;
    step();
    xact(1, 32'h0000_0304, 32'd0, 4'd0, rd, lat);
    check("midreset ram intact", rd, 32'hAAAA_5555);

    // Mode 2: random RAM traffic, latency from reference LFSR, data from scoreboard
    for (int i = 0; i < 64; i++) ref_kn[i] = 4'd0;
    for (int n = 0; n < 1000; n++) begin
      w  = $urandom_range(0, 63);
      ws = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      wd = $urandom;
      mem_instr = 1'($urandom_range(0, 1));
      exp_lat = int'(lfsr_at(edges) & 16'h0007) + 1;
      xact(2, 32'(w * 4), wd, ws, rd, lat);
      check("mode2 latency", 32'(lat), 32'(exp_lat));
      if (ws == 4'd0) begin
        m = {{8{ref_kn[w][3]}}, {8{ref_kn[w][2]}}, {8{ref_kn[w][1]}}, {8{ref_kn[w][0]}}};
        if (m != 32'd0) check("mode2 rdata", rd & m, ref_mem[w] & m);
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (ws[b]) begin
            ref_mem[w][8*b +: 8] = wd[8*b +: 8];
            ref_kn[w][b] = 1'b1;
          end
        end
      end
    end
    mem_instr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
